// File: rtl/operand_loader.sv
// Captures ALU operands/opcode from slide switches on debounced button presses.
// Latency DEBOUNCE_CYCLES+3 edges from raw press to load; no backpressure, coincident presses resolve push1 > push2 > push3 and losers drop.
module operand_loader #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push1,
    input  logic       push2,
    input  logic       push3,
    input  logic [3:0] no,
    output logic [3:0] a,
    output logic [3:0] b,
    output logic [1:0] sel,
    output logic       load_stb,
    output logic [1:0] ld_src
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [2:0]       btn_raw;
    logic [2:0]       btn_s1;
    logic [2:0]       btn_s2;
    logic [3:0]       no_s1;
    logic [3:0]       no_s2;
    logic [2:0]       lvl;
    logic [2:0]       lvl_prev;
    logic [2:0]       press;
    logic [CNT_W-1:0] cnt [3];

    assign btn_raw = {push3, push2, push1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1 <= '0;
            btn_s2 <= '0;
            no_s1  <= '0;
            no_s2  <= '0;
        end else begin
            btn_s1 <= btn_raw;
            btn_s2 <= btn_s1;
            no_s1  <= no;
            no_s2  <= no_s1;
        end
    end

    // Any sample that agrees with the debounced level restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (btn_s2[i] == lvl[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    lvl[i] <= btn_s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_prev <= '0;
            press    <= '0;
        end else begin
            lvl_prev <= lvl;
            press    <= lvl & ~lvl_prev;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a        <= '0;
            b        <= '0;
            sel      <= '0;
            load_stb <= 1'b0;
            ld_src   <= 2'b00;
        end else begin
            load_stb <= |press;
            if (press[0]) begin
                a      <= no_s2;
                ld_src <= 2'b01;
            end else if (press[1]) begin
                b      <= no_s2;
                ld_src <= 2'b10;
            end else if (press[2]) begin
                sel    <= no_s2[1:0];
                ld_src <= 2'b11;
            end else begin
                ld_src <= 2'b00;
            end
        end
    end

endmodule

// File: doc/operand_loader.md
Name: operand_loader

Overview:
- Upstream input stage for the 4-bit ALU. It captures operands A and B and the opcode from the slide switches `no[3:0]` and push buttons push1/push2/push3.
- Each button passes through a 2-flop synchronizer, a debouncer and a rising-edge detector.
- Each debounced press loads exactly one register and emits a one-cycle strobe. The ALU consumes `a`, `b` and `sel` as clean, stable registered values.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive cycles a synchronized button level must differ from the debounced level before the debounced level flips (10 ms at 50 MHz). Legal range 2..2^CNT_W-1.
- CNT_W, 20: width of each debounce counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- push1  input  1  raw button; a press loads operand A.
- push2  input  1  raw button; a press loads operand B.
- push3  input  1  raw button; a press loads the opcode.
- no  input  4  raw slide switches.
- a  output  4  registered operand A.
- b  output  4  registered operand B.
- sel  output  2  registered opcode: 00 add, 01 sub, 10 and, 11 or.
- load_stb  output  1  one-cycle pulse, high in the first cycle a new value is visible on a/b/sel.
- ld_src  output  2  valid with load_stb: 01 = A loaded, 10 = B loaded, 11 = sel loaded; 00 otherwise.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - a, b, sel, load_stb and ld_src are 0.
  - All synchronizer flops, debounced levels, counters and edge registers are 0.
- Synchronizers:
  - push1..3 and no[3:0] each pass through 2 flops (s1, s2).
  - Only the s2 values are used downstream.
- Debouncer, one per button:
  - State: a debounced level `lvl` and a counter `cnt`.
  - If s2 == lvl: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: lvl <= s2 and cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any glitch back to lvl restarts the count from 0.
- Edge detect:
  - press_i <= lvl_i & ~lvl_prev_i, registered, so it is a one-cycle pulse per press.
  - Releases generate no event.
  - Holding a button produces exactly one load.
- Load, on the cycle press_x is high:
  - Value written:
    - press1: a <= no_s2.
    - press2: b <= no_s2.
    - press3: sel <= no_s2[1:0]; no_s2[3:2] is ignored.
  - Priority when press pulses coincide: press1 > press2 > press3.
  - The losing events in the same cycle are dropped, not queued.
  - load_stb and ld_src are registered with the same edge as the loaded value. Both return to 0 the following cycle unless another press occurs.
- Latency:
  - Let raw pushN go high and stay high, with setup before clock edge E0.
  - s2 is high after edge E0+1.
  - lvl is high after edge E0+1+DEBOUNCE_CYCLES.
  - press is high after edge E0+2+DEBOUNCE_CYCLES.
  - The output register and load_stb update after edge E0+3+DEBOUNCE_CYCLES.
  - Total latency: DEBOUNCE_CYCLES+3 edges.
- Switch value used: the no_s2 value present in the load cycle. Switch changes during the debounce window are therefore captured at their latest value.
- Unloaded registers hold their values indefinitely.
- Reset mid-operation:
  - An in-progress count is discarded.
  - A button still held after rst_n deasserts is seen as a new press, since lvl restarts at 0. It loads after the full debounce latency.
- Counter wrap is impossible: cnt never exceeds DEBOUNCE_CYCLES-1.

Test Plan (DEBOUNCE_CYCLES=4 for all scenarios):
1. no=4'hA, push1 held high 20 cycles -> a=4'hA, ld_src=01, with load_stb high for exactly 1 cycle, 7 edges after push1 rises; b=0, sel=0 unchanged; no second strobe while held.
2. push2 toggles high 3 cycles / low 1 cycle, repeated 5 times, then held high 10 cycles with no=4'h3 -> no load during the bounce phase; a single load with b=4'h3 after the steady phase.
3. no=4'b0110, push3 pressed -> sel=2'b10 and ld_src=11; then no=4'hF with push1 pressed -> a=4'hF, sel still 2'b10.
4. push1 and push2 rise in the same cycle, no=4'h5 -> a=4'h5, ld_src=01, one strobe only; b stays 0.
5. push1 held with no=4'h7; rst_n pulsed low for 2 cycles at cycle 4 of the debounce -> outputs 0 during reset; after release, a=4'h7 loads 7 edges after rst_n rises, with one strobe.
6. no changes 4'h1 -> 4'h9 two cycles before the load cycle of a push2 press -> b=4'h9.
